// File: rtl/count_mon_pkg.sv
// Shared types for the count event monitor.
//   state_e : monitor FSM states (INIT seeds tracking, the rest mirror the last step class)
//   delta_e : class of one count step; encodings equal the external dir_state codes
//   Dir*    : 2-bit dir_state codes seen on the top-level port
package count_mon_pkg;

  typedef enum logic [2:0] {
    StInit,
    StHold,
    StUp,
    StDown,
    StJump
  } state_e;

  localparam logic [1:0] DirHold = 2'b00;
  localparam logic [1:0] DirUp   = 2'b01;
  localparam logic [1:0] DirDown = 2'b10;
  localparam logic [1:0] DirJump = 2'b11;

  typedef enum logic [1:0] {
    DeltaHold = 2'b00,
    DeltaUp   = 2'b01,
    DeltaDown = 2'b10,
    DeltaJump = 2'b11
  } delta_e;

  // Tracking state reached after a step of the given class.
  function automatic state_e state_of(input delta_e d);
    state_e s;
    unique case (d)
      DeltaHold: s = StHold;
      DeltaUp:   s = StUp;
      DeltaDown: s = StDown;
      default:   s = StJump;
    endcase
    return s;
  endfunction

  // dir_state code reported for a step of the given class.
  function automatic logic [1:0] dir_of(input delta_e d);
    logic [1:0] c;
    unique case (d)
      DeltaHold: c = DirHold;
      DeltaUp:   c = DirUp;
      DeltaDown: c = DirDown;
      default:   c = DirJump;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/count_delta_classifier.sv
// Combinational classifier for one step of the observed counter.
//   prev_i        : count sampled on the previous edge
//   count_i       : current count
//   delta_class_o : HOLD / UP / DOWN / JUMP from (count - prev) mod 2^WIDTH
//   wrap_up_o     : all-ones -> 0 with a +1 step
//   wrap_dn_o     : 0 -> all-ones with a -1 step
module count_delta_classifier
  import count_mon_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] prev_i,
  input  logic [WIDTH-1:0] count_i,
  output delta_e           delta_class_o,
  output logic             wrap_up_o,
  output logic             wrap_dn_o
);

  localparam logic [WIDTH-1:0] One  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] Ones = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] Zero = {WIDTH{1'b0}};

  logic [WIDTH-1:0] delta;

  // Modular difference: natural truncation gives the mod 2^WIDTH result.
  assign delta = count_i - prev_i;

  always_comb begin
    delta_class_o = DeltaJump;
    if (delta == Zero) begin
      delta_class_o = DeltaHold;
    end else if (delta == One) begin
      delta_class_o = DeltaUp;
    end else if (delta == Ones) begin
      delta_class_o = DeltaDown;
    end
  end

  // Only a genuine +1/-1 step can wrap; a load landing on the same values is a JUMP.
  assign wrap_up_o = (delta == One)  && (prev_i == Ones) && (count_i == Zero);
  assign wrap_dn_o = (delta == Ones) && (prev_i == Zero) && (count_i == Ones);

endmodule

// File: rtl/count_event_monitor.sv
// Passive observer of an up/down/load counter. Classifies every step, pulses on wrap,
// load (jump) and threshold hit, and keeps a saturating wrap tally plus min/max.
//   clk         : rising-edge clock, counter domain
//   reset       : asynchronous active-high reset
//   clr         : synchronous clear of tally and tracking; next sample re-seeds min/max
//   count_in    : observed count
//   thresh      : threshold for match_pulse
//   valid       : a first sample has been captured
//   dir_state   : class of the last step (00 HOLD, 01 UP, 10 DOWN, 11 JUMP)
//   wrap_pulse  : one-cycle wrap indication
//   jump_pulse  : one-cycle load indication
//   match_pulse : one-cycle indication that count_in became equal to thresh
//   wrap_cnt    : saturating wrap tally
//   min_val     : smallest count since start/clr
//   max_val     : largest count since start/clr
module count_event_monitor
  import count_mon_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [WIDTH-1:0] count_in,
  input  logic [WIDTH-1:0] thresh,
  output logic             valid,
  output logic [1:0]       dir_state,
  output logic             wrap_pulse,
  output logic             jump_pulse,
  output logic             match_pulse,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic [WIDTH-1:0] min_val,
  output logic [WIDTH-1:0] max_val
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e           state_q;
  logic [WIDTH-1:0] prev_q;
  // Whether count_in equalled thresh on the previous edge; a match pulses only on the
  // rising edge of this condition, so both count moves and thresh moves are caught.
  logic             hit_q;

  delta_e delta_class;
  logic   wrap_up;
  logic   wrap_dn;
  logic   wrap;
  logic   hit;

  count_delta_classifier #(
    .WIDTH(WIDTH)
  ) u_classifier (
    .prev_i        (prev_q),
    .count_i       (count_in),
    .delta_class_o (delta_class),
    .wrap_up_o     (wrap_up),
    .wrap_dn_o     (wrap_dn)
  );

  assign wrap = wrap_up | wrap_dn;
  assign hit  = (count_in == thresh);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StInit;
      prev_q      <= '0;
      hit_q       <= 1'b0;
      valid       <= 1'b0;
      dir_state   <= DirHold;
      wrap_pulse  <= 1'b0;
      jump_pulse  <= 1'b0;
      match_pulse <= 1'b0;
      wrap_cnt    <= '0;
      min_val     <= '0;
      max_val     <= '0;
    end else if (clr) begin
      // clr overrides any event on this edge; min/max hold until the re-seed.
      state_q     <= StInit;
      hit_q       <= 1'b0;
      valid       <= 1'b0;
      dir_state   <= DirHold;
      wrap_pulse  <= 1'b0;
      jump_pulse  <= 1'b0;
      match_pulse <= 1'b0;
      wrap_cnt    <= '0;
    end else if (state_q == StInit) begin
      // Seed: no step exists yet, so no pulses. hit_q=0 lets a match on the first
      // tracking edge pulse even if the seed already equals thresh.
      state_q     <= StHold;
      prev_q      <= count_in;
      hit_q       <= 1'b0;
      valid       <= 1'b1;
      dir_state   <= DirHold;
      wrap_pulse  <= 1'b0;
      jump_pulse  <= 1'b0;
      match_pulse <= 1'b0;
      min_val     <= count_in;
      max_val     <= count_in;
    end else begin
      state_q     <= state_of(delta_class);
      prev_q      <= count_in;
      hit_q       <= hit;
      dir_state   <= dir_of(delta_class);
      wrap_pulse  <= wrap;
      jump_pulse  <= (delta_class == DeltaJump);
      match_pulse <= hit && !hit_q;
      if (wrap && (wrap_cnt != CntMax)) begin
        wrap_cnt <= wrap_cnt + CntOne;
      end
      if (count_in < min_val) begin
        min_val <= count_in;
      end
      if (count_in > max_val) begin
        max_val <= count_in;
      end
    end
  end

endmodule

// File: tb/tb_count_event_monitor.sv
module tb_count_event_monitor;

  typedef struct packed {
    logic       v;
    logic [1:0] dir;
    logic       wrap;
    logic       jump;
    logic       match;
    logic [7:0] wc;
    logic [1:0] wc2;
    logic [3:0] mn;
    logic [3:0] mx;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr;
  logic [3:0] count_in;
  logic [3:0] thresh;

  logic       valid;
  logic [1:0] dir_state;
  logic       wrap_pulse;
  logic       jump_pulse;
  logic       match_pulse;
  logic [7:0] wrap_cnt;
  logic [3:0] min_val;
  logic [3:0] max_val;

  // Narrow-tally instance, used for the saturation behaviour.
  logic       valid2;
  logic [1:0] dir_state2;
  logic       wrap_pulse2;
  logic       jump_pulse2;
  logic       match_pulse2;
  logic [1:0] wrap_cnt2;
  logic [3:0] min_val2;
  logic [3:0] max_val2;

  int n_vec = 0;
  int n_err = 0;
  int vid   = 0;

  exp_t exp_q[$];
  int   id_q[$];

  always #5 clk = ~clk;

  count_event_monitor #(
    .WIDTH(4),
    .CNT_W(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clr         (clr),
    .count_in    (count_in),
    .thresh      (thresh),
    .valid       (valid),
    .dir_state   (dir_state),
    .wrap_pulse  (wrap_pulse),
    .jump_pulse  (jump_pulse),
    .match_pulse (match_pulse),
    .wrap_cnt    (wrap_cnt),
    .min_val     (min_val),
    .max_val     (max_val)
  );

  count_event_monitor #(
    .WIDTH(4),
    .CNT_W(2)
  ) dut2 (
    .clk         (clk),
    .reset       (reset),
    .clr         (clr),
    .count_in    (count_in),
    .thresh      (thresh),
    .valid       (valid2),
    .dir_state   (dir_state2),
    .wrap_pulse  (wrap_pulse2),
    .jump_pulse  (jump_pulse2),
    .match_pulse (match_pulse2),
    .wrap_cnt    (wrap_cnt2),
    .min_val     (min_val2),
    .max_val     (max_val2)
  );

  function automatic exp_t mk(input logic v, input logic [1:0] dir, input logic wrap,
                              input logic jump, input logic match, input int wc,
                              input int wc2, input int mn, input int mx);
    exp_t e;
    e.v     = v;
    e.dir   = dir;
    e.wrap  = wrap;
    e.jump  = jump;
    e.match = match;
    e.wc    = 8'(wc);
    e.wc2   = 2'(wc2);
    e.mn    = 4'(mn);
    e.mx    = 4'(mx);
    return e;
  endfunction

  function automatic exp_t actual();
    exp_t a;
    a.v     = valid;
    a.dir   = dir_state;
    a.wrap  = wrap_pulse;
    a.jump  = jump_pulse;
    a.match = match_pulse;
    a.wc    = wrap_cnt;
    a.wc2   = wrap_cnt2;
    a.mn    = min_val;
    a.mx    = max_val;
    return a;
  endfunction

  // Drive one sample at the current (falling) edge, queue what must appear after the
  // next rising edge, then move on to the following falling edge.
  task automatic ap(input int c, input int th, input logic cl, input exp_t e);
    count_in = 4'(c);
    thresh   = 4'(th);
    clr      = cl;
    exp_q.push_back(e);
    id_q.push_back(vid);
    vid++;
    @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    exp_t a;
    a = actual();
    n_vec++;
    if (a !== '0) begin
      n_err++;
      $display("FAIL %s: outputs=%h required all zero", name, a);
    end
  endtask

  // Monitor: compare the DUT against the oldest queued expectation after each edge.
  initial begin
    exp_t e;
    exp_t a;
    int   id;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        id = id_q.pop_front();
        a  = actual();
        n_vec++;
        if (a !== e) begin
          n_err++;
          $display("FAIL vec%0d: got v=%0b dir=%0d wrap=%0b jump=%0b match=%0b wc=%0d wc2=%0d min=%0d max=%0d ; required v=%0b dir=%0d wrap=%0b jump=%0b match=%0b wc=%0d wc2=%0d min=%0d max=%0d",
                   id, a.v, a.dir, a.wrap, a.jump, a.match, a.wc, a.wc2, a.mn, a.mx,
                   e.v, e.dir, e.wrap, e.jump, e.match, e.wc, e.wc2, e.mn, e.mx);
        end
      end
    end
  end

  initial begin
    int ewc;
    int ewc2;
    int emx;
    int v;
    logic w;

    reset    = 1'b1;
    clr      = 1'b0;
    count_in = 4'd0;
    thresh   = 4'd7;
    #1;
    check_zero("reset_state");

    @(negedge clk);
    reset = 1'b0;

    // T1: count up 0..15 then wrap to 0 (thresh 7 matches once on the way)
    ap(0, 7, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k < 16; k++) begin
      ap(k, 7, 0, mk(1, 1, 0, 0, (k == 7), 0, 0, 0, k));
    end
    ap(0, 7, 0, mk(1, 1, 1, 0, 0, 1, 1, 0, 15));

    // T2: load to 3, count down through 0 to 15
    ap(3, 7, 0, mk(1, 3, 0, 1, 0, 1, 1, 0, 15));
    ap(2, 7, 0, mk(1, 2, 0, 0, 0, 1, 1, 0, 15));
    ap(1, 7, 0, mk(1, 2, 0, 0, 0, 1, 1, 0, 15));
    ap(0, 7, 0, mk(1, 2, 0, 0, 0, 1, 1, 0, 15));
    ap(15, 7, 0, mk(1, 2, 1, 0, 0, 2, 2, 0, 15));

    // T3: loads 15->2->9, then up, load to 15, then a real 15->0 up-wrap
    ap(2, 7, 0, mk(1, 3, 0, 1, 0, 2, 2, 0, 15));
    ap(9, 7, 0, mk(1, 3, 0, 1, 0, 2, 2, 0, 15));
    ap(10, 7, 0, mk(1, 1, 0, 0, 0, 2, 2, 0, 15));
    ap(15, 7, 0, mk(1, 3, 0, 1, 0, 2, 2, 0, 15));
    ap(0, 7, 0, mk(1, 1, 1, 0, 0, 3, 3, 0, 15));

    // T4: thresh 5, counts 4,5,5,6,5 then thresh moved off and back onto the count
    ap(4, 5, 0, mk(1, 3, 0, 1, 0, 3, 3, 0, 15));
    ap(5, 5, 0, mk(1, 1, 0, 0, 1, 3, 3, 0, 15));
    ap(5, 5, 0, mk(1, 0, 0, 0, 0, 3, 3, 0, 15));
    ap(6, 5, 0, mk(1, 1, 0, 0, 0, 3, 3, 0, 15));
    ap(5, 5, 0, mk(1, 2, 0, 0, 1, 3, 3, 0, 15));
    ap(5, 3, 0, mk(1, 0, 0, 0, 0, 3, 3, 0, 15));
    ap(5, 5, 0, mk(1, 0, 0, 0, 1, 3, 3, 0, 15));

    // clr: tally and valid drop, min/max hold; next edge re-seeds
    ap(5, 5, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 15));
    ap(0, 8, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));

    // T5: five full up-count laps; the 2-bit tally saturates at 3
    ewc  = 0;
    ewc2 = 0;
    emx  = 0;
    for (int lap = 0; lap < 5; lap++) begin
      for (int k = 1; k <= 16; k++) begin
        v = k % 16;
        w = (v == 0);
        if (w) begin
          ewc++;
          if (ewc2 < 3) ewc2++;
        end
        if (v > emx) emx = v;
        ap(v, 8, 0, mk(1, 1, w, 0, (v == 8), ewc, ewc2, 0, emx));
      end
    end

    // T6: down-wrap, then clr coincident with a 15->0 up-wrap, then re-seed
    ap(15, 8, 0, mk(1, 2, 1, 0, 0, 6, 3, 0, 15));
    ap(0, 8, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 15));
    ap(3, 8, 0, mk(1, 0, 0, 0, 0, 0, 0, 3, 3));
    ap(1, 8, 0, mk(1, 3, 0, 1, 0, 0, 0, 1, 3));
    ap(2, 8, 0, mk(1, 1, 0, 0, 0, 0, 0, 1, 3));

    // Asynchronous reset between edges clears outputs without waiting for a clock
    #2;
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    ap(7, 8, 0, mk(1, 0, 0, 0, 0, 0, 0, 7, 7));
    ap(8, 8, 0, mk(1, 1, 0, 0, 1, 0, 0, 7, 8));

    repeat (3) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
